muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative N-bit multiply/divide unit for the execute stage of the pipelined core.
//  Computes MULT/MULTU into {hi,lo} and DIV/DIVU into lo=quotient, hi=remainder, one bit per cycle.
//  Owns the HI/LO architectural registers, including their mthi/mtlo writes.
//  Asserts busy so the hazard unit stalls mfhi/mflo and further muldiv ops until done.
// PARAMETERS
//  N        64   operand/result width (even, >=8)
//  CNT_W    $clog2(N)+1   iteration counter width (derived, not overridden)
// PORTS
//  clk       in   1    clock, rising edge
//  reset     in   1    asynchronous, active-low reset
//  start     in   1    launch op with srca/srcb/op this cycle
//  op        in   2    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srca      in   N    multiplicand / dividend
//  srcb      in   N    multiplier / divisor
//  flush     in   1    abort in-flight op (pipeline flush of issuing instr)
//  hilo_we   in   2    [1] write hi, [0] write lo (mthi/mtlo)
//  wdata     in   N    mthi/mtlo data
//  busy      out  1    op in progress; muldiv/mfhi/mflo must stall
//  done      out  1    one-cycle pulse: hi/lo hold new result this cycle
//  hi        out  N    HI register
//  lo        out  N    LO register
// BEHAVIOUR
//  - reset low: state=IDLE, hi=lo=0, busy=0, done=0, counter=0; takes effect immediately, aborts any op.
//  - FSM IDLE -> RUN -> DONE. start sampled in IDLE or DONE (back-to-back); ignored in RUN.
//  - start at edge t: operands latched (magnitudes if signed op), counter=N; RUN cycles t+1..t+N;
//    final iteration result written to hi/lo at edge t+N+1; DONE (done=1, busy=0) that cycle; then IDLE.
//  - busy=1 exactly in RUN (N cycles). done never asserted together with busy.
//  - MULT(U): {hi,lo} = full 2N-bit product, shift-add, 1 multiplier bit/cycle.
//  - DIV(U): restoring division, 1 quotient bit/cycle; lo=quotient, hi=remainder.
//  - signed div: quotient truncates toward zero; remainder takes dividend's sign.
//  - divide by zero: lo = all ones, hi = srca (raw dividend), for signed and unsigned; no trap.
//  - signed overflow (min_int / -1): lo = min_int, hi = 0.
//  - flush in RUN: -> IDLE next edge, hi/lo unchanged, no done. flush with start same cycle: flush wins, start dropped.
//  - hilo_we: honoured only when not RUN; written at edge, visible next cycle. Ignored in RUN.
//    hilo_we in the DONE cycle: mthi/mtlo value overrides result in that register (later instr wins).
//  - hilo_we and start same cycle: write applied, op launches; op result later overwrites.
//  - all arithmetic unsigned internally on N/2N-bit regs; sign fix-up applied once at DONE write.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: op 00/10 are signed (operand negate on entry, result negate on exit).
//  MULDIV_SIGNED_EN undefined: op[0] ignored, 00/10 behave exactly as 01/11; no sign logic synthesised.
//  Latency identical in both configurations.
// TESTING
//  1 reset low mid-RUN (cycle 10 of MULTU) -> immediately busy=0, done=0, hi=lo=0; next start works normally.
//  2 MULTU srca=0xFFFF_FFFF_FFFF_FFFF, srcb=2 -> done exactly N+1=65 cycles after start edge, hi=1, lo=0xFFFF_FFFF_FFFF_FFFE.
//  3 DIV srca=-7, srcb=2 -> with MULDIV_SIGNED_EN lo=-3, hi=-1; without, lo=0x7FFF_FFFF_FFFF_FFFC, hi=1.
//  4 DIVU srca=10, srcb=0 -> lo=0xFFFF_FFFF_FFFF_FFFF, hi=10; DIV min_int/-1 (signed build) -> lo=min_int, hi=0.
//  5 start MULTU, flush at RUN cycle 5 -> no done pulse, hi/lo keep prior values, start next cycle accepted, completes in 65.
//  6 hilo_we=10, wdata=0x1234 in IDLE -> hi=0x1234 next cycle; same write during RUN ignored; start during RUN ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers; one result bit per cycle.
// Optional signed MULT/DIV support is compiled in with `define MULDIV_SIGNED_EN.
module muldiv_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic         flush,
  input  logic [1:0]   hilo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_r;
  logic             div0_r;
  logic [N-1:0]     a_raw_r;
  logic [N-1:0]     opnd_r;
  logic [2*N-1:0]   prod_r;
  logic             busy_r;
  logic             done_r;
  logic [N-1:0]     hi_r;
  logic [N-1:0]     lo_r;

  logic             launch_s;
  logic             borrow_s;
  logic [N-1:0]     mag_a_s;
  logic [N-1:0]     mag_b_s;
  logic [N:0]       sum_s;
  logic [N+1:0]     diff_s;
  logic [2*N-1:0]   next_s;
  logic [N-1:0]     res_hi_s;
  logic [N-1:0]     res_lo_s;

  assign launch_s = (state_r != RUN) && start && !flush;

`ifdef MULDIV_SIGNED_EN
  logic neg_a_s;
  logic neg_b_s;
  logic neg_q_r;
  logic neg_r_r;

  // Operand magnitudes for signed ops (op[0]==0)
  always_comb begin
    neg_a_s = ~op[0] & srca[N-1];
    neg_b_s = ~op[0] & srcb[N-1];
    if (neg_a_s) mag_a_s = {N{1'b0}} - srca;
    else         mag_a_s = srca;
    if (neg_b_s) mag_b_s = {N{1'b0}} - srcb;
    else         mag_b_s = srcb;
  end

  // Result sign flags captured at launch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (launch_s) begin
      neg_q_r <= neg_a_s ^ neg_b_s;
      neg_r_r <= neg_a_s;
    end
  end

  // Final result: sign fix-up, divide-by-zero override
  always_comb begin
    res_hi_s = next_s[2*N-1:N];
    res_lo_s = next_s[N-1:0];
    if (is_div_r) begin
      if (div0_r) begin
        res_hi_s = a_raw_r;
        res_lo_s = {N{1'b1}};
      end else begin
        if (neg_q_r) res_lo_s = {N{1'b0}} - next_s[N-1:0];
        else         res_lo_s = next_s[N-1:0];
        if (neg_r_r) res_hi_s = {N{1'b0}} - next_s[2*N-1:N];
        else         res_hi_s = next_s[2*N-1:N];
      end
    end else begin
      if (neg_q_r) {res_hi_s, res_lo_s} = {(2*N){1'b0}} - next_s;
      else         {res_hi_s, res_lo_s} = next_s;
    end
  end
`else
  logic unused_op0_s;
  assign unused_op0_s = op[0];

  // Unsigned-only build: operands pass straight through
  always_comb begin
    mag_a_s = srca;
    mag_b_s = srcb;
  end

  // Final result with divide-by-zero override
  always_comb begin
    if (is_div_r && div0_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = {N{1'b1}};
    end else begin
      res_hi_s = next_s[2*N-1:N];
      res_lo_s = next_s[N-1:0];
    end
  end
`endif

  // One shift-add or restoring-subtract step on {upper, lower}
  always_comb begin
    sum_s    = {1'b0, prod_r[2*N-1:N]} + (prod_r[0] ? {1'b0, opnd_r} : {(N+1){1'b0}});
    diff_s   = {1'b0, prod_r[2*N-1:N-1]} - {2'b00, opnd_r};
    borrow_s = (diff_s[N+1:N] != 2'b00);
    if (is_div_r) begin
      if (borrow_s) next_s = {prod_r[2*N-2:0], 1'b0};
      else          next_s = {diff_s[N-1:0], prod_r[N-2:0], 1'b1};
    end else begin
      next_s = {sum_s, prod_r[N-1:1]};
    end
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
      div0_r   <= 1'b0;
      a_raw_r  <= {N{1'b0}};
      opnd_r   <= {N{1'b0}};
      prod_r   <= {(2*N){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {N{1'b0}};
      lo_r     <= {N{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          done_r <= 1'b0;
          if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_ONE) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            prod_r <= next_s;
            cnt_r  <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          done_r <= 1'b0;
          // mthi/mtlo land here; a launching op overwrites them when it finishes
          if (hilo_we[1]) hi_r <= wdata;
          if (hilo_we[0]) lo_r <= wdata;
          if (launch_s) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            cnt_r    <= CNT_INIT;
            is_div_r <= op[1];
            div0_r   <= (srcb == {N{1'b0}});
            a_raw_r  <= srca;
            if (op[1]) begin
              opnd_r <= mag_b_s;
              prod_r <= {{N{1'b0}}, mag_a_s};
            end else begin
              opnd_r <= mag_a_s;
              prod_r <= {{N{1'b0}}, mag_b_s};
            end
          end else begin
            state_r <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, expected results queued at issue,
// compared by a monitor on every done pulse.
module tb_muldiv_unit;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] srca;
  logic [N-1:0] srcb;
  logic         flush;
  logic [1:0]   hilo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int n_tests;
  int n_fail;

  logic [N-1:0] exp_hi_q[$];
  logic [N-1:0] exp_lo_q[$];
  string        name_q[$];

`ifdef MULDIV_SIGNED_EN
  localparam logic [N-1:0] DIV7_LO  = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [N-1:0] DIV7_HI  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [N-1:0] OVF_LO   = 64'h8000_0000_0000_0000;
  localparam logic [N-1:0] OVF_HI   = 64'h0000_0000_0000_0000;
  localparam logic [N-1:0] MULN_HI  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [N-1:0] MULN_LO  = 64'hFFFF_FFFF_FFFF_FFF1;
`else
  localparam logic [N-1:0] DIV7_LO  = 64'h7FFF_FFFF_FFFF_FFFC;
  localparam logic [N-1:0] DIV7_HI  = 64'h0000_0000_0000_0001;
  localparam logic [N-1:0] OVF_LO   = 64'h0000_0000_0000_0000;
  localparam logic [N-1:0] OVF_HI   = 64'h8000_0000_0000_0000;
  localparam logic [N-1:0] MULN_HI  = 64'h0000_0000_0000_0004;
  localparam logic [N-1:0] MULN_LO  = 64'hFFFF_FFFF_FFFF_FFF1;
`endif

  muldiv_unit #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .flush   (flush),
    .hilo_we (hilo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (busy === 1'b1 && done === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL busy_done_overlap: got busy=1 done=1, expected never both");
      end
      if (done === 1'b1) begin
        if (exp_hi_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
        end else begin
          automatic logic [N-1:0] eh = exp_hi_q.pop_front();
          automatic logic [N-1:0] el = exp_lo_q.pop_front();
          automatic string        nm = name_q.pop_front();
          chk({nm, "_hi"}, hi, eh);
          chk({nm, "_lo"}, lo, el);
        end
      end
    end
  end

  task automatic run_to_done(input string name);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        start = 1'b0;
        chk({name, "_busy"}, {63'b0, busy}, 64'd1);
      end
    end while (done !== 1'b1 && k < 200);
    chk({name, "_latency"}, 64'(k), 64'(N + 1));
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eh, input logic [N-1:0] el, input string name);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_idle"}, {63'b0, busy}, 64'd0);
    op    = o;
    srca  = a;
    srcb  = b;
    start = 1'b1;
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    name_q.push_back(name);
    run_to_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    srca    = '0;
    srcb    = '0;
    flush   = 1'b0;
    hilo_we = 2'b00;
    wdata   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    reset = 1'b1;

    // mthi / mtlo in IDLE
    @(posedge clk);
    #1;
    hilo_we = 2'b10;
    wdata   = 64'h1234;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    chk("mthi_hi", hi, 64'h1234);
    chk("mthi_lo", lo, 64'h0);
    hilo_we = 2'b01;
    wdata   = 64'h55;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    chk("mtlo_lo", lo, 64'h55);
    chk("mtlo_hi", hi, 64'h1234);

    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, "multu_max2");

    // Reset mid-RUN, RUN cycle 10
    op    = 2'b01;
    srca  = 64'd3;
    srcb  = 64'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_hi", hi, 64'd0);
    chk("midrst_lo", lo, 64'd0);
    #2;
    reset = 1'b1;
    issue(2'b01, 64'd3, 64'd5, 64'd0, 64'd15, "multu_3x5");

    issue(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV7_HI, DIV7_LO, "div_m7_2");

    // Divide by zero, then mtlo in the DONE cycle overrides lo
    issue(2'b11, 64'd10, 64'd0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0");
    hilo_we = 2'b01;
    wdata   = 64'hABCD;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    chk("donewr_lo", lo, 64'hABCD);
    chk("donewr_hi", hi, 64'd10);

    issue(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OVF_HI, OVF_LO, "div_ovf");

    // Back-to-back: second start issued in the DONE cycle
    issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, MULN_HI, MULN_LO, "mult_m3x5");
    issue(2'b11, 64'd100, 64'd7, 64'd2, 64'd14, "divu_100_7");

    // Flush at RUN cycle 5
    op    = 2'b01;
    srca  = 64'd7;
    srcb  = 64'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hi", hi, 64'd2);
    chk("flush_lo", lo, 64'd14);
    issue(2'b01, 64'd7, 64'd9, 64'd0, 64'd63, "multu_7x9");

    // flush and start together: start dropped
    op    = 2'b01;
    srca  = 64'd5;
    srcb  = 64'd5;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flushstart_busy", {63'b0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // hilo_we and start during RUN are ignored
    op    = 2'b01;
    srca  = 64'd2;
    srcb  = 64'd3;
    start = 1'b1;
    exp_hi_q.push_back(64'd0);
    exp_lo_q.push_back(64'd6);
    name_q.push_back("multu_2x3");
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hilo_we = 2'b11;
    wdata   = 64'hDEAD;
    op      = 2'b11;
    srca    = 64'd100;
    srcb    = 64'd7;
    start   = 1'b1;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    start   = 1'b0;
    chk("runwr_hi", hi, 64'd0);
    chk("runwr_lo", lo, 64'd63);
    chk("runwr_busy", {63'b0, busy}, 64'd1);
    for (int k = 0; k < 100 && done !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    chk("run_ign_done", {63'b0, done}, 64'd1);
    chk("run_ign_lo", lo, 64'd6);
    repeat (80) @(posedge clk);
    #1;
    chk("sb_empty", 64'(exp_hi_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
